branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 116 +++++++++++
 tb/tb_branch_predictor.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// +----------------------------------------------------------------------------+
// | branch_predictor: direct-mapped BTB with 2-bit saturating direction counters|
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef SYS_XLEN
`define SYS_XLEN 32
`endif

module branch_predictor #(
  parameter int BP_ENTRIES = 32,
  parameter int IDX_W      = $clog2(BP_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bp_lookup_en,
  input  logic [`SYS_XLEN-1:0] bp_lookup_pc,
  output logic                 bp_pred_hit,
  output logic                 bp_pred_taken,
  output logic [`SYS_XLEN-1:0] bp_pred_target,
  input  logic                 bs_upd_en,
  input  logic [`SYS_XLEN-1:0] bs_upd_pc,
  input  logic                 bs_upd_taken,
  input  logic [`SYS_XLEN-1:0] bs_upd_target
);

  localparam int                c_xlen     = `SYS_XLEN;
  localparam int                c_tag_w    = c_xlen - IDX_W - 2;
  localparam logic [c_xlen-1:0] c_pc_step  = c_xlen'(4);
  localparam logic [1:0]        c_ctr_rst  = 2'b01;
  localparam logic [1:0]        c_ctr_new  = 2'b10;

  logic                r_valid  [BP_ENTRIES];
  logic [c_tag_w-1:0]  r_tag    [BP_ENTRIES];
  logic [c_xlen-1:0]   r_target [BP_ENTRIES];
  logic [1:0]          r_ctr    [BP_ENTRIES];

  logic [IDX_W-1:0]    w_lk_idx;
  logic [c_tag_w-1:0]  w_lk_tag;
  logic                w_lk_hit;
  logic                w_lk_taken;

  logic [IDX_W-1:0]    w_up_idx;
  logic [c_tag_w-1:0]  w_up_tag;
  logic                w_up_hit;
  logic [1:0]          w_up_ctr_next;

  // Word-alignment bits never participate in index or tag.
  logic                w_unused_pc_lsbs;
  assign w_unused_pc_lsbs = ^{bp_lookup_pc[1:0], bs_upd_pc[1:0]};

  function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic up);
    logic [1:0] res;
    res = ctr;
    if (up && ctr != 2'b11) begin
      res = ctr + 2'b01;
    end else if (!up && ctr != 2'b00) begin
      res = ctr - 2'b01;
    end
    return res;
  endfunction

  // Lookup path reads only registered state, so a same-cycle update is not bypassed.
  always_comb begin
    w_lk_idx   = bp_lookup_pc[IDX_W+1:2];
    w_lk_tag   = bp_lookup_pc[c_xlen-1:IDX_W+2];
    w_lk_hit   = bp_lookup_en && r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    w_lk_taken = w_lk_hit && r_ctr[w_lk_idx][1];
  end

  always_comb begin
    bp_pred_hit    = 1'b0;
    bp_pred_taken  = 1'b0;
    bp_pred_target = '0;
    if (bp_lookup_en) begin
      bp_pred_hit    = w_lk_hit;
      bp_pred_taken  = w_lk_taken;
      bp_pred_target = w_lk_taken ? r_target[w_lk_idx] : (bp_lookup_pc + c_pc_step);
    end
  end

  always_comb begin
    w_up_idx      = bs_upd_pc[IDX_W+1:2];
    w_up_tag      = bs_upd_pc[c_xlen-1:IDX_W+2];
    w_up_hit      = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    w_up_ctr_next = sat_step(r_ctr[w_up_idx], bs_upd_taken);
  end

  // Not-taken misses are dropped so a cold branch never evicts a trained entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BP_ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= c_ctr_rst;
      end
    end else if (bs_upd_en) begin
      if (w_up_hit) begin
        r_ctr[w_up_idx] <= w_up_ctr_next;
        if (bs_upd_taken) begin
          r_target[w_up_idx] <= bs_upd_target;
        end
      end else if (bs_upd_taken) begin
        r_valid[w_up_idx]  <= 1'b1;
        r_tag[w_up_idx]    <= w_up_tag;
        r_target[w_up_idx] <= bs_upd_target;
        r_ctr[w_up_idx]    <= c_ctr_new;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// +----------------------------------------------------------------------------+
// | tb_branch_predictor: vector table and scoreboard bench for branch_predictor |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef SYS_XLEN
`define SYS_XLEN 32
`endif

module tb_branch_predictor;

  localparam int c_xlen = `SYS_XLEN;
  localparam int c_nvec = 26;

  typedef struct {
    logic              rst;
    logic              lk_en;
    logic [c_xlen-1:0] lk_pc;
    logic              up_en;
    logic [c_xlen-1:0] up_pc;
    logic              up_taken;
    logic [c_xlen-1:0] up_tgt;
    logic              e_hit;
    logic              e_taken;
    logic [c_xlen-1:0] e_tgt;
  } vec_t;

  typedef struct {
    string             name;
    logic              hit;
    logic              taken;
    logic [c_xlen-1:0] tgt;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              bp_lookup_en;
  logic [c_xlen-1:0] bp_lookup_pc;
  logic              bp_pred_hit;
  logic              bp_pred_taken;
  logic [c_xlen-1:0] bp_pred_target;
  logic              bs_upd_en;
  logic [c_xlen-1:0] bs_upd_pc;
  logic              bs_upd_taken;
  logic [c_xlen-1:0] bs_upd_target;

  int   checks;
  int   errors;
  exp_t sb_q [$];
  vec_t vecs [c_nvec];

  branch_predictor #(.BP_ENTRIES(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .bp_lookup_en   (bp_lookup_en),
    .bp_lookup_pc   (bp_lookup_pc),
    .bp_pred_hit    (bp_pred_hit),
    .bp_pred_taken  (bp_pred_taken),
    .bp_pred_target (bp_pred_target),
    .bs_upd_en      (bs_upd_en),
    .bs_upd_pc      (bs_upd_pc),
    .bs_upd_taken   (bs_upd_taken),
    .bs_upd_target  (bs_upd_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic le, input logic [c_xlen-1:0] lp,
                              input logic ue, input logic [c_xlen-1:0] up, input logic ut,
                              input logic [c_xlen-1:0] ug, input logic eh, input logic et,
                              input logic [c_xlen-1:0] eg);
    vec_t v;
    v.rst = r;  v.lk_en = le; v.lk_pc = lp;
    v.up_en = ue; v.up_pc = up; v.up_taken = ut; v.up_tgt = ug;
    v.e_hit = eh; v.e_taken = et; v.e_tgt = eg;
    return v;
  endfunction

  // One cycle: drive after the edge, queue the expectation, check on the falling edge.
  task automatic apply(input vec_t v, input string name);
    exp_t e;
    exp_t got;
    @(posedge clk);
    #1;
    rst           = v.rst;
    bp_lookup_en  = v.lk_en;
    bp_lookup_pc  = v.lk_pc;
    bs_upd_en     = v.up_en;
    bs_upd_pc     = v.up_pc;
    bs_upd_taken  = v.up_taken;
    bs_upd_target = v.up_tgt;
    e.name = name; e.hit = v.e_hit; e.taken = v.e_taken; e.tgt = v.e_tgt;
    sb_q.push_back(e);
    @(negedge clk);
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      got = sb_q.pop_front();
      if (bp_pred_hit !== got.hit || bp_pred_taken !== got.taken || bp_pred_target !== got.tgt) begin
        errors++;
        $display("FAIL %s: got hit=%0b taken=%0b target=%h, want hit=%0b taken=%0b target=%h",
                 got.name, bp_pred_hit, bp_pred_taken, bp_pred_target, got.hit, got.taken, got.tgt);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [c_xlen-1:0] a;
    logic [c_xlen-1:0] b;
    logic [c_xlen-1:0] c;
    a = 32'h1000_0000;
    b = 32'h1000_0080;
    c = 32'h1000_0100;
    checks = 0;
    errors = 0;
    rst = 1'b1; bp_lookup_en = 1'b0; bp_lookup_pc = '0;
    bs_upd_en = 1'b0; bs_upd_pc = '0; bs_upd_taken = 1'b0; bs_upd_target = '0;

    //              rst le pc               ue pc               ut tgt              eh et exp_tgt
    vecs[0]  = mk(1, 0, a,               0, '0,              0, '0,              0, 0, 32'h0);
    vecs[1]  = mk(1, 0, a,               1, a,               1, 32'h1000_0040,   0, 0, 32'h0);
    vecs[2]  = mk(0, 1, a,               0, '0,              0, '0,              0, 0, 32'h1000_0004);
    vecs[3]  = mk(0, 0, a,               1, a,               1, 32'h1000_0040,   0, 0, 32'h0);
    vecs[4]  = mk(0, 1, a,               1, 32'h1000_0010,   0, 32'h1000_0999,   1, 1, 32'h1000_0040);
    vecs[5]  = mk(0, 1, 32'h1000_0010,   0, '0,              0, '0,              0, 0, 32'h1000_0014);
    vecs[6]  = mk(0, 1, a,               1, a,               0, 32'h0,           1, 1, 32'h1000_0040);
    vecs[7]  = mk(0, 1, a,               1, a,               0, 32'h0,           1, 0, 32'h1000_0004);
    vecs[8]  = mk(0, 1, a,               1, a,               1, 32'h1000_0040,   1, 0, 32'h1000_0004);
    vecs[9]  = mk(0, 1, a,               1, a,               1, 32'h1000_0040,   1, 0, 32'h1000_0004);
    vecs[10] = mk(0, 1, a,               1, a,               1, 32'h1000_0040,   1, 1, 32'h1000_0040);
    vecs[11] = mk(0, 1, a,               1, a,               1, 32'h1000_0040,   1, 1, 32'h1000_0040);
    vecs[12] = mk(0, 1, a,               1, a,               0, 32'h0,           1, 1, 32'h1000_0040);
    vecs[13] = mk(0, 1, a,               0, '0,              0, '0,              1, 1, 32'h1000_0040);
    vecs[14] = mk(0, 1, a,               1, a,               1, 32'h1000_0044,   1, 1, 32'h1000_0040);
    vecs[15] = mk(0, 1, a,               0, '0,              0, '0,              1, 1, 32'h1000_0044);
    vecs[16] = mk(0, 1, b,               1, b,               1, 32'h2000_0000,   0, 0, 32'h1000_0084);
    vecs[17] = mk(0, 1, a,               0, '0,              0, '0,              0, 0, 32'h1000_0004);
    vecs[18] = mk(0, 1, b,               0, '0,              0, '0,              1, 1, 32'h2000_0000);
    vecs[19] = mk(0, 1, c,               1, c,               1, 32'h1000_0200,   0, 0, 32'h1000_0104);
    vecs[20] = mk(0, 1, c,               0, '0,              0, '0,              1, 1, 32'h1000_0200);
    vecs[21] = mk(0, 1, c,               1, b,               0, 32'h3000_0000,   1, 1, 32'h1000_0200);
    vecs[22] = mk(0, 1, c,               0, '0,              0, '0,              1, 1, 32'h1000_0200);
    vecs[23] = mk(0, 1, 32'hFFFF_FFFC,   0, '0,              0, '0,              0, 0, 32'h0000_0000);
    vecs[24] = mk(0, 0, c,               0, '0,              0, '0,              0, 0, 32'h0);
    vecs[25] = mk(0, 1, 32'h1000_0102,   0, '0,              0, '0,              1, 1, 32'h1000_0200);

    for (int i = 0; i < c_nvec; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Mid-operation reset with a concurrent update must wipe all learned state.
    apply(mk(0, 0, a, 1, a, 1, 32'h1000_0040, 0, 0, 32'h0), "rst_train");
    apply(mk(0, 1, a, 0, '0, 0, '0, 1, 1, 32'h1000_0040), "rst_trained_hit");
    apply(mk(1, 0, a, 1, a, 1, 32'h1000_0040, 0, 0, 32'h0), "rst_pulse");
    apply(mk(0, 1, a, 0, '0, 0, '0, 0, 0, 32'h1000_0004), "rst_cold_a");
    apply(mk(0, 1, c, 0, '0, 0, '0, 0, 0, 32'h1000_0104), "rst_cold_c");

    // Not-taken update after reset must not allocate.
    apply(mk(0, 0, a, 1, a, 0, 32'h1000_0040, 0, 0, 32'h0), "nt_noalloc_upd");
    apply(mk(0, 1, a, 0, '0, 0, '0, 0, 0, 32'h1000_0004), "nt_noalloc_look");

    @(posedge clk);
    #1;
    bp_lookup_en = 1'b0;
    bs_upd_en    = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
